// File: rtl/riscv_pkg.sv
// Shared types and default widths for the row URAM arbiter.
package riscv_pkg;

    localparam int DEFAULT_NUM_CORES       = 4;
    localparam int DEFAULT_URAM_ADDR_WIDTH = 12;
    localparam int DEFAULT_DATA_WIDTH      = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWNED   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/row_uram_arbiter_picker.sv
// Round-robin first-set search: picks the first request at or after ptr, wrapping.
// Purely combinational; one-hot sel plus valid.
module rr_priority_picker
    import riscv_pkg::*;
#(
    parameter int NUM_CORES = DEFAULT_NUM_CORES,
    parameter int PTR_WIDTH = $clog2(DEFAULT_NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [PTR_WIDTH-1:0] ptr,
    output logic [NUM_CORES-1:0] sel,
    output logic                 valid
);

    logic [PTR_WIDTH-1:0] idx;

    always_comb begin
        sel   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            idx = PTR_WIDTH'((int'(ptr) + i) % NUM_CORES);
            if (!valid && req[idx]) begin
                sel[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/row_uram_arbiter.sv
// Shares one row URAM between cores: round-robin grant with lock hold, registered URAM mux,
// and a saturating written-word counter that drives the emptied broadcast.
module row_uram_arbiter
    import riscv_pkg::*;
#(
    parameter int NUM_CORES       = DEFAULT_NUM_CORES,
    parameter int URAM_ADDR_WIDTH = DEFAULT_URAM_ADDR_WIDTH,
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_CORES-1:0]                  i_core_req,
    input  logic [NUM_CORES-1:0]                  i_core_locked,
    output logic [NUM_CORES-1:0]                  o_core_grant,
    input  logic [NUM_CORES-1:0]                  i_core_uram_en,
    input  logic [NUM_CORES*URAM_ADDR_WIDTH-1:0]  i_core_uram_addr,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]       i_core_uram_wr_data,
    input  logic [NUM_CORES-1:0]                  i_core_uram_wr_en,
    output logic                                  o_uram_en,
    output logic [URAM_ADDR_WIDTH-1:0]            o_uram_addr,
    output logic [DATA_WIDTH-1:0]                 o_uram_wr_data,
    output logic                                  o_uram_wr_en,
    input  logic                                  i_uram_drained,
    output logic                                  o_uram_emptied
);

    localparam int PW = $clog2(NUM_CORES);
    localparam int CW = URAM_ADDR_WIDTH + 1;
    localparam logic [CW-1:0] WR_MAX = {1'b1, {URAM_ADDR_WIDTH{1'b0}}};

    arb_state_t           state, state_next;
    logic [PW-1:0]        owner, owner_next, rr_ptr, rr_ptr_next, pick_idx;
    logic [NUM_CORES-1:0] grant_next, pick_sel;
    logic                 pick_vld;

    logic                       mux_en, mux_wr_en, wr_hit;
    logic [URAM_ADDR_WIDTH-1:0] mux_addr;
    logic [DATA_WIDTH-1:0]      mux_wr_data;
    logic [CW-1:0]              wr_count, wr_count_next;

    rr_priority_picker #(
        .NUM_CORES (NUM_CORES),
        .PTR_WIDTH (PW)
    ) u_picker (
        .req   (i_core_req),
        .ptr   (rr_ptr),
        .sel   (pick_sel),
        .valid (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (pick_sel[i]) pick_idx = PW'(i);
        end
    end

    always_comb begin
        state_next  = state;
        owner_next  = owner;
        rr_ptr_next = rr_ptr;
        grant_next  = o_core_grant;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_next = OWNED;
                    owner_next = pick_idx;
                    grant_next = pick_sel;
                end
            end
            OWNED: begin
                if (!i_core_req[owner] && !i_core_locked[owner]) begin
                    state_next  = RELEASE;
                    grant_next  = '0;
                    rr_ptr_next = (owner == PW'(NUM_CORES - 1)) ? '0 : owner + 1'b1;
                end
            end
            RELEASE: state_next = IDLE;
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            owner        <= '0;
            rr_ptr       <= '0;
            o_core_grant <= '0;
        end else begin
            state        <= state_next;
            owner        <= owner_next;
            rr_ptr       <= rr_ptr_next;
            o_core_grant <= grant_next;
        end
    end

    // Only the current owner reaches the URAM; everyone else is masked to zero.
    always_comb begin
        mux_en      = 1'b0;
        mux_wr_en   = 1'b0;
        mux_addr    = '0;
        mux_wr_data = '0;
        if (state == OWNED) begin
            mux_en      = i_core_uram_en[owner];
            mux_wr_en   = i_core_uram_wr_en[owner];
            mux_addr    = i_core_uram_addr[int'(owner)*URAM_ADDR_WIDTH +: URAM_ADDR_WIDTH];
            mux_wr_data = i_core_uram_wr_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // A drain and a write in the same cycle keep the write.
    always_comb begin
        wr_hit        = o_uram_en & o_uram_wr_en;
        wr_count_next = wr_count;
        if (i_uram_drained) begin
            wr_count_next = wr_hit ? CW'(1) : '0;
        end else if (wr_hit && wr_count != WR_MAX) begin
            wr_count_next = wr_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_uram_en      <= 1'b0;
            o_uram_wr_en   <= 1'b0;
            o_uram_addr    <= '0;
            o_uram_wr_data <= '0;
            wr_count       <= '0;
            o_uram_emptied <= 1'b1;
        end else begin
            o_uram_en      <= mux_en;
            o_uram_wr_en   <= mux_wr_en;
            o_uram_addr    <= mux_addr;
            o_uram_wr_data <= mux_wr_data;
            wr_count       <= wr_count_next;
            o_uram_emptied <= (wr_count_next == '0);
        end
    end

endmodule
